aer_dual_rail_tx: RTL and testbench

AER_DUAL_RAIL_TX -- requirements
Module: aer_dual_rail_tx

---
 rtl/aer_pkg.sv | 27 ++
 rtl/aer_dual_rail_tx_if.sv | 26 ++
 rtl/aer_sync2.sv | 20 ++
 rtl/aer_dual_rail_tx.sv | 147 ++++++++++++++
 tb/tb_aer_dual_rail_tx.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aer_pkg.sv
// Shared definitions for the AER dual-rail link (transmitter and receiver).
package aer_pkg;

  localparam int AER_ADDR_W  = 8;
  localparam int AER_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SPACER  = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_RTZ     = 3'd4,
    ST_WAIT_LO = 3'd5,
    ST_DONE    = 3'd6
  } aer_state_e;

  // Dual-rail code word {one, nought} for a single data bit.
  function automatic logic [1:0] aer_rails(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  // States in which the link waits on the receiver and the timeout runs.
  function automatic logic aer_is_wait(input aer_state_e s);
    return (s == ST_SPACER) || (s == ST_WAIT_HI) || (s == ST_WAIT_LO);
  endfunction

endpackage

// File: rtl/aer_dual_rail_tx_if.sv
// Event-in / dual-rail-out bundle of the AER transmitter.
interface aer_dual_rail_tx_if #(
  parameter int ADDR_W = aer_pkg::AER_ADDR_W
);
  logic [ADDR_W-1:0] ev_addr;
  logic              ev_valid;
  logic              ev_ready;
  logic              ack;
  logic              nought;
  logic              one;
  logic              busy;
  logic              done;
  logic              err;

  // Transmitter side.
  modport master (
    input  ev_addr, ev_valid, ack,
    output ev_ready, nought, one, busy, done, err
  );

  // Upstream source plus receiver side.
  modport slave (
    output ev_addr, ev_valid, ack,
    input  ev_ready, nought, one, busy, done, err
  );
endinterface

// File: rtl/aer_sync2.sv
// Two-flop synchronizer for an asynchronous level input.
module aer_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  // Capture the asynchronous level through two flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/aer_dual_rail_tx.sv
// AER transmitter: sends an address event MSB first over a 4-phase
// return-to-zero dual-rail link, one bit per handshake.
module aer_dual_rail_tx
  import aer_pkg::*;
#(
  parameter int ADDR_W  = AER_ADDR_W,
  parameter int TIMEOUT = AER_TIMEOUT
) (
  input logic clk,
  input logic reset,
  aer_dual_rail_tx_if.master bus
);
  localparam int CNT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  aer_state_e        state, state_nx;
  logic [ADDR_W-1:0] shreg, shreg_nx;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [1:0]        rails, rails_nx;
  logic              ready, active, done_pulse, err_pulse, err_nx;
  logic              ack_s, accept, tmo_hit;

  aer_sync2 u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.ack),
    .q     (ack_s)
  );

  assign accept  = bus.ev_valid & ready;
  // One cycle before the counter would reach TIMEOUT, so err lands TIMEOUT cycles after entry.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Next-state, shift register and output decode; outputs follow the next state so they stay registered.
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    err_nx     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx   = ST_SPACER;
          shreg_nx   = bus.ev_addr;
          bit_cnt_nx = BIT_LAST;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SPACER: begin
        if (!ack_s) begin
          state_nx = ST_DRIVE;
        end else if (tmo_hit) begin
          state_nx = ST_IDLE;
          err_nx   = 1'b1;
        end else begin
          state_nx = ST_SPACER;
        end
      end
      ST_DRIVE: begin
        state_nx = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (ack_s) begin
          state_nx = ST_RTZ;
        end else if (tmo_hit) begin
          state_nx = ST_IDLE;
          err_nx   = 1'b1;
        end else begin
          state_nx = ST_WAIT_HI;
        end
      end
      ST_RTZ: begin
        state_nx = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!ack_s) begin
          if (bit_cnt == {CNT_W{1'b0}}) begin
            state_nx = ST_DONE;
          end else begin
            state_nx   = ST_DRIVE;
            shreg_nx   = {shreg[ADDR_W-2:0], 1'b0};
            bit_cnt_nx = bit_cnt - CNT_W'(1);
          end
        end else if (tmo_hit) begin
          state_nx = ST_IDLE;
          err_nx   = 1'b1;
        end else begin
          state_nx = ST_WAIT_LO;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    // The rail is held from DRIVE through WAIT_HI; every other state is a spacer.
    if ((state_nx == ST_DRIVE) || (state_nx == ST_WAIT_HI)) begin
      rails_nx = aer_rails(shreg_nx[ADDR_W-1]);
    end else begin
      rails_nx = 2'b00;
    end
  end

  // State, datapath, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= {ADDR_W{1'b0}};
      bit_cnt    <= {CNT_W{1'b0}};
      tmo_cnt    <= {TMO_W{1'b0}};
      rails      <= 2'b00;
      ready      <= 1'b0;
      active     <= 1'b0;
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      bit_cnt    <= bit_cnt_nx;
      rails      <= rails_nx;
      ready      <= (state_nx == ST_IDLE);
      active     <= (state_nx != ST_IDLE);
      done_pulse <= (state_nx == ST_DONE);
      err_pulse  <= err_nx;
      if (state_nx != state) begin
        tmo_cnt <= {TMO_W{1'b0}};
      end else if (aer_is_wait(state)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= {TMO_W{1'b0}};
      end
    end
  end

  assign bus.one      = rails[1];
  assign bus.nought   = rails[0];
  assign bus.ev_ready = ready;
  assign bus.busy     = active;
  assign bus.done     = done_pulse;
  assign bus.err      = err_pulse;
endmodule

// File: tb/tb_aer_dual_rail_tx.sv
// Directed bench for aer_dual_rail_tx with a 4-phase receiver model and token scoreboard.
`timescale 1ns/1ps
module tb_aer_dual_rail_tx;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aer_dual_rail_tx_if #(.ADDR_W(ADDR_W)) bus ();

  aer_dual_rail_tx #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] exp_q[$];
  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         rx_limit = -1;
  int         rx_tok   = 0;
  int         rise_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver model: ack 2 cycles after a rail, release 2 cycles after RTZ.
  task automatic rx_loop();
    int         phase = 0;
    int         cd = 0;
    logic [1:0] tok = 2'b00;
    logic [1:0] rails;
    logic [1:0] want;
    logic       mute = 1'b0;
    forever begin
      @(negedge clk); #1;
      rails = {bus.one, bus.nought};
      if (reset) begin
        phase   = 0;
        bus.ack = 1'b0;
      end else begin
        case (phase)
          0: if (rails != 2'b00) begin
               tok      = rails;
               rise_cyc = cyc;
               mute     = (rx_limit >= 0) && (rx_tok >= rx_limit);
               rx_tok++;
               if (exp_q.size() == 0) begin
                 chk("token_extra", 32'(rails), 32'd0);
               end else begin
                 want = exp_q.pop_front();
                 chk("token", 32'(rails), 32'(want));
               end
               cd    = 2;
               phase = 1;
             end
          1: if (rails == 2'b00) begin
               if (!mute) chk("rail_early_drop", 32'(rails), 32'(tok));
               phase = 0;
             end else begin
               chk("rail_stable", 32'(rails), 32'(tok));
               if (!mute) begin
                 if (cd <= 1) begin bus.ack = 1'b1; phase = 2; end
                 else cd--;
               end
             end
          2: if (rails == 2'b00) begin cd = 2; phase = 3; end
             else chk("rail_hold", 32'(rails), 32'(tok));
          3: begin
               chk("rtz_spacer", 32'(rails), 32'd0);
               if (cd <= 1) begin bus.ack = 1'b0; phase = 0; end
               else cd--;
             end
          default: phase = 0;
        endcase
      end
    end
  endtask

  // Per-cycle protocol monitor and pulse counters.
  task automatic mon_loop();
    forever begin
      @(negedge clk); #1;
      chk("rails_exclusive", 32'(bus.nought & bus.one), 32'd0);
      chk("ready_vs_busy", 32'(bus.ev_ready & bus.busy), 32'd0);
      if (bus.done) done_cnt++;
      if (bus.err)  err_cnt++;
    end
  endtask

  task automatic push_tokens(input logic [7:0] a);
    for (int i = 7; i >= 0; i--) exp_q.push_back(a[i] ? 2'b10 : 2'b01);
  endtask

  task automatic send_event(input logic [7:0] a, input string tag);
    int t = 0;
    bus.ev_addr  = a;
    bus.ev_valid = 1'b1;
    while (!bus.ev_ready && t < 600) begin @(negedge clk); t++; end
    chk({tag, "_ready"}, 32'(bus.ev_ready), 32'd1);
    push_tokens(a);
    @(negedge clk);
    bus.ev_valid = 1'b0;
    bus.ev_addr  = ~a;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!bus.done && t < 2000) begin @(negedge clk); t++; end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_done_rails"}, 32'({bus.one, bus.nought}), 32'd0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_ready"}, 32'(bus.ev_ready), 32'd1);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, t;
    reset        = 1'b1;
    bus.ev_valid = 1'b0;
    bus.ev_addr  = 8'h00;
    bus.ack      = 1'b0;
    fork
      rx_loop();
      mon_loop();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_nought", 32'(bus.nought), 32'd0);
    chk("rst_one", 32'(bus.one), 32'd0);
    chk("rst_ready", 32'(bus.ev_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.ev_ready), 32'd1);

    // 8'hA5 with prompt receiver
    d0 = done_cnt; e0 = err_cnt;
    send_event(8'hA5, "a5");
    wait_done("a5");
    chk("a5_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("a5_err_cnt", 32'(err_cnt - e0), 32'd0);

    // 8'h00 then 8'hFF with ev_valid held
    d0 = done_cnt;
    bus.ev_addr  = 8'h00;
    bus.ev_valid = 1'b1;
    push_tokens(8'h00);
    chk("b2b_ready0", 32'(bus.ev_ready), 32'd1);
    @(negedge clk);
    bus.ev_addr = 8'hFF;
    push_tokens(8'hFF);
    t = 0;
    while (!bus.done && t < 2000) begin
      chk("b2b_ready_low", 32'(bus.ev_ready), 32'd0);
      @(negedge clk);
      t++;
    end
    chk("b2b_first_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("b2b_ready_gap", 32'(bus.ev_ready), 32'd1);
    @(negedge clk);
    bus.ev_valid = 1'b0;
    chk("b2b_busy2", 32'(bus.busy), 32'd1);
    wait_done("b2b_ff");
    chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);

    // ack held high across accept
    d0 = done_cnt;
    bus.ack = 1'b1;
    repeat (3) @(negedge clk);
    send_event(8'hC3, "hold");
    repeat (9) begin
      @(negedge clk);
      chk("hold_rails_low", 32'({bus.one, bus.nought}), 32'd0);
    end
    bus.ack = 1'b0;
    @(negedge clk);
    chk("hold_rel1", 32'({bus.one, bus.nought}), 32'd0);
    @(negedge clk);
    chk("hold_rel2", 32'({bus.one, bus.nought}), 32'd0);
    @(negedge clk);
    chk("hold_rail_on", 32'({bus.one, bus.nought} != 2'b00), 32'd1);
    wait_done("hold");
    chk("hold_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Receiver goes silent on the fourth bit of 8'h3C
    d0 = done_cnt; e0 = err_cnt;
    rx_tok   = 0;
    rx_limit = 3;
    send_event(8'h3C, "tmo");
    t = 0;
    while (!bus.err && t < TIMEOUT + 300) begin @(negedge clk); t++; end
    chk("tmo_err", 32'(bus.err), 32'd1);
    chk("tmo_tokens", 32'(rx_tok), 32'd4);
    chk("tmo_cycle", 32'(cyc), 32'(rise_cyc + 1 + TIMEOUT));
    @(negedge clk);
    chk("tmo_err_1cyc", 32'(bus.err), 32'd0);
    chk("tmo_rails", 32'({bus.one, bus.nought}), 32'd0);
    chk("tmo_ready", 32'(bus.ev_ready), 32'd1);
    chk("tmo_err_cnt", 32'(err_cnt - e0), 32'd1);
    chk("tmo_done_cnt", 32'(done_cnt - d0), 32'd0);
    exp_q.delete();
    rx_limit = -1;

    // Reset while 'one' is driven mid-word
    d0 = done_cnt; e0 = err_cnt;
    rx_tok = 0;
    send_event(8'hA5, "rst");
    t = 0;
    while (!(rx_tok >= 4 && bus.one) && t < 500) begin @(negedge clk); t++; end
    chk("rst_mid_one", 32'(bus.one), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_one_low", 32'(bus.one), 32'd0);
    chk("rst_mid_nought_low", 32'(bus.nought), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_ready0", 32'(bus.ev_ready), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_ready1", 32'(bus.ev_ready), 32'd1);
    chk("rst_mid_done_cnt", 32'(done_cnt - d0), 32'd0);
    chk("rst_mid_err_cnt", 32'(err_cnt - e0), 32'd0);

    // Normal transfer after the mid-word reset
    d0 = done_cnt;
    send_event(8'h96, "post");
    wait_done("post");
    chk("post_done_cnt", 32'(done_cnt - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
